chain_mult_ctrl: RTL and testbench

Sequencer for the 32x8 register file in the chain-multiplier datapath. It owns the register file's ports and arbitrates the single write port between a host loader and its own result write-back. On start, it reads a chain of N consecutive operands two per read using read ports I and J, and multiplies them into an 8-bit accumulator. It then writes the truncated product back to a destination register and pulses done.

---
 rtl/chain_mult_pkg.sv | 17 +
 rtl/chain_mult_alu.sv | 28 ++
 rtl/chain_mult_ctrl.sv | 159 +++++++++++++++
 tb/tb_chain_mult_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chain_mult_pkg.sv
// Shared types and constants for the chain-multiplier sequencer.
// Holds the FSM state enum, default widths and the maximum chain length.
package chain_mult_pkg;

  localparam int CM_ADDR_W = 5;
  localparam int CM_DATA_W = 8;
  localparam int MAX_COUNT = 2 ** CM_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MUL,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/chain_mult_alu.sv
// Combinational multiply step: acc * a * (use_b ? b : 1) at 3*DATA_W bits.
// Ports: acc, a, b, use_b in; prod_lo (low DATA_W bits), ovf (upper bits nonzero) out.
import chain_mult_pkg::*;

module chain_mult_alu #(
  parameter int DATA_W = CM_DATA_W
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              use_b,
  output logic [DATA_W-1:0] prod_lo,
  output logic              ovf
);

  localparam int PW = 3 * DATA_W;

  logic [PW-1:0] b_eff;
  logic [PW-1:0] prod;

  always_comb begin
    b_eff   = use_b ? PW'(b) : PW'(1);
    prod    = PW'(acc) * PW'(a) * b_eff;
    prod_lo = prod[DATA_W-1:0];
    ovf     = |prod[PW-1:DATA_W];
  end

endmodule

// File: rtl/chain_mult_ctrl.sv
// Chain-multiply sequencer owning the register-file ports (host loader + write-back).
// Ports: clk/rst, host write channel, start/base/count/dst, status, rf write and read selects.
import chain_mult_pkg::*;

module chain_mult_ctrl #(
  parameter int ADDR_W = CM_ADDR_W,
  parameter int DATA_W = CM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              error,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_sel,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_sel_oI,
  output logic [ADDR_W-1:0] rf_sel_oJ,
  output logic [ADDR_W-1:0] rf_sel_oK,
  input  logic [DATA_W-1:0] rf_rd_i,
  input  logic [DATA_W-1:0] rf_rd_j
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] TWO     = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic              use_b;
  logic [DATA_W-1:0] alu_lo;
  logic              alu_ovf;

  assign use_b = (rem_q >= TWO);

  chain_mult_alu #(.DATA_W(DATA_W)) u_alu (
    .acc     (acc_q),
    .a       (rf_rd_i),
    .b       (rf_rd_j),
    .use_b   (use_b),
    .prod_lo (alu_lo),
    .ovf     (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      dst_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      dst_q    <= dst_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rem_d         = rem_q;
    dst_d         = dst_q;
    acc_d         = acc_q;
    result_d      = result_q;
    ovf_d         = ovf_q;
    err_d         = err_q;
    host_wr_ready = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    rf_wr_en      = 1'b0;
    rf_wr_sel     = '0;
    rf_wr_data    = '0;
    rf_sel_oI     = '0;
    rf_sel_oJ     = '0;
    unique case (state_q)
      S_IDLE: begin
        busy          = 1'b0;
        host_wr_ready = 1'b1;
        rf_wr_en      = host_wr_en;
        rf_wr_sel     = host_wr_addr;
        rf_wr_data    = host_wr_data;
        if (start) begin
          ovf_d = 1'b0;
          if (count == '0 || count > MAX_CNT) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            ptr_d   = base_addr;
            rem_d   = count;
            dst_d   = dst_addr;
            acc_d   = DATA_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        rf_sel_oI = ptr_q;
        rf_sel_oJ = ptr_q + ADDR_W'(1);
        state_d   = S_MUL;
      end
      S_MUL: begin
        acc_d = alu_lo;
        ovf_d = ovf_q | alu_ovf;
        if (use_b) begin
          ptr_d = ptr_q + ADDR_W'(2);
          rem_d = rem_q - TWO;
        end else begin
          rem_d = rem_q - ONE;
        end
        state_d = (rem_d == '0) ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        rf_wr_en   = 1'b1;
        rf_wr_sel  = dst_q;
        rf_wr_data = acc_q;
        result_d   = acc_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign error     = err_q;
  assign rf_sel_oK = '0;

endmodule

// File: tb/tb_chain_mult_ctrl.sv
// Bench for chain_mult_ctrl: register-file model, reference model, directed + random ops.
// Reports each mismatch and ends with one summary line.
module tb_chain_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_wr_en;
  logic [4:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic       host_wr_ready;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] count;
  logic [4:0] dst_addr;
  logic       busy, done, overflow, error;
  logic [7:0] result;
  logic       rf_wr_en;
  logic [4:0] rf_wr_sel;
  logic [7:0] rf_wr_data;
  logic [4:0] rf_sel_oI, rf_sel_oJ, rf_sel_oK;
  logic [7:0] rf_rd_i, rf_rd_j;

  logic [7:0] mem [32];
  logic       mem_clr;

  int checks = 0;
  int errors = 0;

  int         cyc, wrs;
  logic       timeout;
  logic [4:0] si, sj;
  int         exp_res, exp_ovf;

  always #5 clk = ~clk;

  chain_mult_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .host_wr_ready(host_wr_ready),
    .start        (start),
    .base_addr    (base_addr),
    .count        (count),
    .dst_addr     (dst_addr),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .overflow     (overflow),
    .error        (error),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_sel    (rf_wr_sel),
    .rf_wr_data   (rf_wr_data),
    .rf_sel_oI    (rf_sel_oI),
    .rf_sel_oJ    (rf_sel_oJ),
    .rf_sel_oK    (rf_sel_oK),
    .rf_rd_i      (rf_rd_i),
    .rf_rd_j      (rf_rd_j)
  );

  // Register file: write cycles write, other cycles capture both reads.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      rf_rd_i <= 8'h00;
      rf_rd_j <= 8'h00;
    end else if (rf_wr_en) begin
      mem[rf_wr_sel] <= rf_wr_data;
    end else begin
      rf_rd_i <= mem[rf_sel_oI];
      rf_rd_j <= mem[rf_sel_oJ];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [4:0] a, input logic [7:0] d);
    host_wr_en   = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    tick();
    host_wr_en   = 1'b0;
  endtask

  // Chain product taken pairwise, acc truncated to 8 bits after each step.
  task automatic model(input int b, input int c);
    longint acc, t, x, y;
    int p, r;
    acc = 1; exp_ovf = 0; p = b; r = c;
    while (r > 0) begin
      x = longint'(mem[p]);
      y = (r >= 2) ? longint'(mem[(p + 1) % 32]) : 1;
      t = acc * x * y;
      if (t > 255) exp_ovf = 1;
      acc = t % 256;
      p = (p + 2) % 32;
      r = (r >= 2) ? r - 2 : 0;
    end
    exp_res = int'(acc);
  endtask

  task automatic run_op(input logic [4:0] b, input logic [5:0] c,
                        input logic [4:0] d, input bit interfere);
    start     = 1'b1;
    base_addr = b;
    count     = c;
    dst_addr  = d;
    tick();
    start      = 1'b0;
    host_wr_en = 1'b0;
    model(int'(b), int'(c));
    cyc = 1; wrs = 0; timeout = 1'b0; si = '0; sj = '0;
    while (1) begin
      if (cyc == 1) begin si = rf_sel_oI; sj = rf_sel_oJ; end
      if (rf_wr_en) wrs++;
      if (interfere && cyc == 2) begin
        chk("ready_low_busy", host_wr_ready, 0);
        start        = 1'b1;
        host_wr_en   = 1'b1;
        host_wr_addr = b;
        host_wr_data = 8'hEE;
        base_addr    = b + 5'd1;
        count        = 6'd1;
      end
      if (interfere && cyc == 3) begin
        start      = 1'b0;
        host_wr_en = 1'b0;
      end
      if (done) break;
      if (cyc >= 100) begin timeout = 1'b1; break; end
      tick();
      cyc++;
    end
    chk("timeout", timeout, 0);
  endtask

  task automatic check_op(input string tag, input logic [5:0] c,
                          input logic [4:0] d);
    int n, ec;
    n = int'(c);
    ec = (n == 0 || n > 32) ? 1 : 2 * ((n + 1) / 2) + 2;
    chk({tag, "_done_cyc"}, cyc, ec);
    if (n == 0 || n > 32) begin
      chk({tag, "_error"}, error, 1);
      chk({tag, "_no_wr"}, wrs, 0);
    end else begin
      chk({tag, "_error"}, error, 0);
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_ovf"}, overflow, exp_ovf);
      chk({tag, "_wr_once"}, wrs, 1);
      chk({tag, "_rf_dst"}, mem[d], exp_res);
    end
    tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    start = 1'b0; base_addr = '0; count = '0; dst_addr = '0;
    tick();
    tick();
    rst = 1'b0; mem_clr = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", error, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_sel", {rf_sel_oI, rf_sel_oJ, rf_sel_oK}, 0);
    chk("rst_ready", host_wr_ready, 1);

    host_wr(5'd4, 8'd2);
    host_wr(5'd5, 8'd3);
    host_wr(5'd6, 8'd4);
    run_op(5'd4, 6'd3, 5'd10, 1'b0);
    chk("t1_const", result, 24);
    check_op("t1", 6'd3, 5'd10);

    host_wr(5'd0, 8'd16);
    host_wr(5'd1, 8'd16);
    run_op(5'd0, 6'd2, 5'd2, 1'b0);
    chk("t2_ovf_const", overflow, 1);
    check_op("t2", 6'd2, 5'd2);

    host_wr(5'd31, 8'd5);
    host_wr(5'd0, 8'd7);
    run_op(5'd31, 6'd2, 5'd3, 1'b0);
    chk("t3_sel_i", si, 31);
    chk("t3_sel_j", sj, 0);
    chk("t3_const", result, 35);
    check_op("t3", 6'd2, 5'd3);

    run_op(5'd0, 6'd0, 5'd7, 1'b0);
    check_op("cnt0", 6'd0, 5'd7);
    run_op(5'd0, 6'd33, 5'd7, 1'b0);
    check_op("cnt33", 6'd33, 5'd7);

    run_op(5'd4, 6'd3, 5'd11, 1'b1);
    chk("intf_const", result, 24);
    check_op("intf", 6'd3, 5'd11);
    chk("intf_host_dropped", mem[4], 2);
    chk("intf_no_restart", busy, 0);

    host_wr_en = 1'b1; host_wr_addr = 5'd8; host_wr_data = 8'd9;
    run_op(5'd8, 6'd1, 5'd12, 1'b0);
    chk("same_cyc_const", result, 9);
    check_op("same_cyc", 6'd1, 5'd12);

    host_wr(5'd20, 8'h77);
    start = 1'b1; base_addr = 5'd4; count = 6'd4; dst_addr = 5'd20;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_en", rf_wr_en, 0);
    wrs = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || rf_wr_en) wrs++;
      tick();
    end
    chk("abort_quiet", wrs, 0);
    chk("abort_dst", mem[20], 8'h77);

    for (int it = 0; it < 25; it++) begin
      logic [4:0] rb, rd;
      logic [5:0] rc;
      for (int w = 0; w < 6; w++) begin
        if ($urandom_range(0, 3) == 0)
          host_wr(5'($urandom), 8'($urandom));
        else
          host_wr(5'($urandom), 8'($urandom_range(1, 3)));
      end
      rb = 5'($urandom);
      rd = 5'($urandom);
      if ($urandom_range(0, 7) == 0)
        rc = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(33, 63));
      else
        rc = 6'($urandom_range(1, 32));
      run_op(rb, rc, rd, 1'b0);
      check_op("rand", rc, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
